fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the 16-bit program RAM port (one-cycle read latency),
// assembles 16/32-bit RISC-V instructions and hands them to decode over valid/ready.
// Optional feature macro: FETCH_RVC_EN enables compressed (16-bit) instruction decode;
// without it the unit is RV32I-only, fetching word-aligned 32-bit instructions.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter logic [ADDR_WIDTH:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_q,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH:0]   redirect_pc,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH:0]   instr_pc,
  output logic                  instr_compressed,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  localparam logic [1:0] REQ = 2'd0;
  localparam logic [1:0] LO  = 2'd1;
  localparam logic [1:0] HI  = 2'd2;
  localparam logic [1:0] OUT = 2'd3;

  localparam logic [ADDR_WIDTH:0] PC_INIT = {RESET_PC[ADDR_WIDTH:1], 1'b0};

  logic [1:0]            state, state_next;
  logic [ADDR_WIDTH:0]   pc, pc_next;
  logic [15:0]           lo, lo_next;
  logic [31:0]           instr_next;
  logic [ADDR_WIDTH:0]   instr_pc_next;
  logic                  comp_next, valid_next;
  logic [ADDR_WIDTH:0]   target_pc;
  logic [ADDR_WIDTH:0]   step_pc;
  logic                  is_rvc;
  logic [ADDR_WIDTH-1:0] pc_hw;

  assign pc_hw = pc[ADDR_WIDTH:1];

`ifdef FETCH_RVC_EN
  logic unused_redirect_bits;
  assign unused_redirect_bits = redirect_pc[0];
  assign target_pc = {redirect_pc[ADDR_WIDTH:1], 1'b0};
  // step_pc is only consumed in OUT, where instr_compressed describes the held instruction
  assign step_pc   = instr_compressed ? (pc + PW'(2)) : (pc + PW'(4));
  assign is_rvc    = (mem_q[1:0] != 2'b11);
`else
  logic unused_redirect_bits;
  assign unused_redirect_bits = redirect_pc[1] ^ redirect_pc[0];
  assign target_pc = {redirect_pc[ADDR_WIDTH:2], 2'b00};
  assign step_pc   = pc + PW'(4);
  assign is_rvc    = 1'b0;
`endif

  // RAM address: redirect target wins, otherwise the halfword each state needs next
  always_comb begin
    mem_addr = pc_hw;
    if (redirect && rst_n) begin
      mem_addr = target_pc[ADDR_WIDTH:1];
    end else begin
      case (state)
        REQ:     mem_addr = pc_hw;
        LO:      mem_addr = pc_hw + ADDR_WIDTH'(1);
        HI:      mem_addr = pc_hw + ADDR_WIDTH'(2);
        default: mem_addr = step_pc[ADDR_WIDTH:1];
      endcase
    end
  end

  // Next-state: fetch sequencing, instruction assembly and handshake
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    lo_next       = lo;
    instr_next    = instr;
    instr_pc_next = instr_pc;
    comp_next     = instr_compressed;
    valid_next    = instr_valid;
    if (redirect) begin
      // Target address is already on mem_addr, so resume directly in LO
      state_next = LO;
      pc_next    = target_pc;
      valid_next = 1'b0;
    end else begin
      case (state)
        REQ: state_next = LO;
        LO: begin
          if (is_rvc) begin
            instr_next    = {16'h0000, mem_q};
            comp_next     = 1'b1;
            instr_pc_next = pc;
            valid_next    = 1'b1;
            state_next    = OUT;
          end else begin
            lo_next    = mem_q;
            state_next = HI;
          end
        end
        HI: begin
          instr_next    = {mem_q, lo};
          comp_next     = 1'b0;
          instr_pc_next = pc;
          valid_next    = 1'b1;
          state_next    = OUT;
        end
        default: begin
          if (instr_ready) begin
            pc_next    = step_pc;
            valid_next = 1'b0;
            state_next = LO;
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= REQ;
      pc               <= PC_INIT;
      lo               <= '0;
      instr            <= '0;
      instr_pc         <= '0;
      instr_compressed <= 1'b0;
      instr_valid      <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      lo               <= lo_next;
      instr            <= instr_next;
      instr_pc         <= instr_pc_next;
      instr_compressed <= comp_next;
      instr_valid      <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a synchronous program RAM model.
// Expected values are hand-computed for both FETCH_RVC_EN builds.
module tb_fetch_unit;

  localparam int unsigned AW = 8;

`ifdef FETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [AW:0] pc;
    logic        comp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_q;
  logic          redirect;
  logic [AW:0]   redirect_pc;
  logic [31:0]   instr;
  logic [AW:0]   instr_pc;
  logic          instr_compressed;
  logic          instr_valid;
  logic          instr_ready;

  int   vectors = 0;
  int   errors  = 0;
  exp_t exp_q[$];
  logic [15:0] mem [256];

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (9'h000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr         (mem_addr),
    .mem_q            (mem_q),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready)
  );

  always #5 clk = ~clk;

  // RAM read port: data one cycle after address
  always @(posedge clk) mem_q <= mem[mem_addr];

  function automatic exp_t mk(input logic [31:0] i, input logic [AW:0] p, input logic c);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    e.comp  = c;
    return e;
  endfunction

  // Monitor: every accepted instruction must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && instr_valid && instr_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr: actual instr=%h pc=%h, required no instruction",
                 instr, instr_pc);
      end else begin
        e = exp_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc || instr_compressed !== e.comp) begin
          errors++;
          $display("FAIL accept: actual instr=%h pc=%h c=%b, required instr=%h pc=%h c=%b",
                   instr, instr_pc, instr_compressed, e.instr, e.pc, e.comp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      vectors++;
      errors++;
      $display("FAIL %s: actual=timeout required=valid within %0d cycles", name, max_cyc);
    end
  endtask

  // Hold ready for exactly one handshake of the instruction currently valid
  task automatic accept_one();
    @(posedge clk); #1 instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    exp_t i2;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0013;
    mem[0]   = 16'h4501;
    mem[1]   = 16'h0513;
    mem[2]   = 16'h0000;
    mem[3]   = 16'h0093;
    mem[4]   = 16'h0000;
    mem[5]   = 16'h0113;
    mem[6]   = 16'h0000;
    mem[128] = 16'h8082;
    mem[129] = 16'h00ef;
    mem[255] = 16'h0093;

    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", 32'(instr_pc), 32'h0);
    check("rst_comp", 32'(instr_compressed), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);

    exp_q.push_back(RVC ? mk(32'h00004501, 9'h000, 1'b1) : mk(32'h05134501, 9'h000, 1'b0));
    exp_q.push_back(RVC ? mk(32'h00000513, 9'h002, 1'b0) : mk(32'h00930000, 9'h004, 1'b0));
    @(posedge clk); #1 rst_n = 1'b1;

    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!instr_valid && edges < 10);
    check("first_latency", 32'(edges), RVC ? 32'd2 : 32'd3);

    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!instr_valid && edges < 10);
    check("second_latency", 32'(edges), 32'd3);

    // Backpressure on the third instruction
    i2 = RVC ? mk(32'h00000093, 9'h006, 1'b0) : mk(32'h01130000, 9'h008, 1'b0);
    exp_q.push_back(i2);
    @(posedge clk); #1 instr_ready = 1'b0;
    wait_valid("i2_valid", 10);
    repeat (5) begin
      check("hold_instr", instr, i2.instr);
      check("hold_pc", 32'(instr_pc), 32'(i2.pc));
      check("hold_addr", 32'(mem_addr), RVC ? 32'h05 : 32'h06);
      @(negedge clk);
    end
    check("hold_valid", 32'(instr_valid), 32'h1);
    @(posedge clk); #1 instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;

    // Redirect while the next 32-bit instruction is half assembled
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 9'h100;
    @(negedge clk);
    check("redir_hi_addr", 32'(mem_addr), 32'h80);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("redir_hi_valid", 32'(instr_valid), 32'h0);
    exp_q.push_back(RVC ? mk(32'h00008082, 9'h100, 1'b1) : mk(32'h00ef8082, 9'h100, 1'b0));
    wait_valid("r0_valid", 10);
    check("r0_next_addr", 32'(mem_addr), RVC ? 32'h81 : 32'h82);

    // Redirect coinciding with a handshake; target exercises the address wrap
    @(posedge clk); #1 instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 9'h1FE;
    @(negedge clk);
    check("redir_out_addr", 32'(mem_addr), RVC ? 32'hFF : 32'hFE);
    @(posedge clk); #1 redirect = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("redir_out_valid", 32'(instr_valid), 32'h0);
    check("wrap_lo_addr", 32'(mem_addr), RVC ? 32'h00 : 32'hFF);
    exp_q.push_back(RVC ? mk(32'h45010093, 9'h1FE, 1'b0) : mk(32'h00930013, 9'h1FC, 1'b0));
    wait_valid("w0_valid", 10);
    check("wrap_next_addr", 32'(mem_addr), RVC ? 32'h01 : 32'h00);
    accept_one();
    exp_q.push_back(RVC ? mk(32'h00000513, 9'h002, 1'b0) : mk(32'h05134501, 9'h000, 1'b0));
    wait_valid("w1_valid", 10);
    accept_one();

    // Reset mid-operation drops the pending instruction
    wait_valid("x_valid", 10);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(instr_valid), 32'h0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_pc", 32'(instr_pc), 32'h0);
    check("midrst_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
